// File: rtl/full_stage_ctrl_param_if.sv
// Bus bundle between the stage controller/datapath and full_stage_ctrl_param.
// slave = the control block's view, master = the surrounding stage's view.
interface full_stage_ctrl_param_if #(
  parameter int WIDTH   = 32,
  parameter int NTAPS   = 6,
  parameter int DATA_AW = 6,
  parameter int TAP_AW  = 4,
  parameter int PHASE_W = 2
);
  logic                     active, active_normal, active_pre, active_start_d;
  logic                     fb_en, bias_fb_en;
  logic                     data_valid;
  logic [DATA_AW-1:0]       data_write_addr, data_read_addr;
  logic [WIDTH-1:0]         data_value;
  logic [TAP_AW-1:0]        tap_address, bias_wr_address;
  logic                     error_valid;
  logic [WIDTH-1:0]         error_value;
  logic [31:0]              error_sub_address;
  logic [PHASE_W-1:0]       error_phase, error_phase_read;
  logic                     error_update_first, error_update_latch, error_tap_update_out;
  logic [WIDTH-1:0]         st_data_out, st_data_out_pre, st_bias_out;
  logic [WIDTH*NTAPS-1:0]   st_tap_out;
  logic [WIDTH-1:0]         data_rd_data, bias_rd_data;
  logic [WIDTH*NTAPS-1:0]   tap_rd_data;
  logic                     out_rdy, pre_rdy;

  logic                     data_wr_vld, data_rd_vld;
  logic [DATA_AW-1:0]       data_wr_addr, data_rd_addr;
  logic [WIDTH-1:0]         data_wr_data;
  logic                     tap_rd_vld, tap_wr_vld, tap_sub_vld, tap_inter, tap_inter_first;
  logic [TAP_AW-1:0]        tap_rd_addr, tap_wr_addr;
  logic [WIDTH*NTAPS-1:0]   tap_wr_data;
  logic [31:0]              tap_sub_addr;
  logic [WIDTH-1:0]         tap_sub_data;
  logic                     bias_rd_vld, bias_wr_vld;
  logic [TAP_AW-1:0]        bias_rd_addr, bias_wr_addr;
  logic [WIDTH-1:0]         bias_wr_data;
  logic [WIDTH*NTAPS-1:0]   taps;
  logic [WIDTH-1:0]         st_data, st_bias;
  logic                     first;
  logic [WIDTH-1:0]         out_data, pre_data;
  logic                     out_vld, pre_vld;
  logic                     err_pend, err_drop;

  modport slave (
    input  active, active_normal, active_pre, active_start_d, fb_en, bias_fb_en,
           data_valid, data_write_addr, data_value, data_read_addr,
           tap_address, bias_wr_address, error_valid, error_value, error_sub_address,
           error_phase, error_phase_read, error_update_first, error_update_latch,
           error_tap_update_out, st_data_out, st_data_out_pre, st_bias_out, st_tap_out,
           data_rd_data, bias_rd_data, tap_rd_data, out_rdy, pre_rdy,
    output data_wr_vld, data_wr_addr, data_wr_data, data_rd_vld, data_rd_addr,
           tap_rd_vld, tap_rd_addr, tap_wr_vld, tap_wr_addr, tap_wr_data,
           tap_sub_vld, tap_sub_addr, tap_sub_data, tap_inter, tap_inter_first,
           bias_rd_vld, bias_rd_addr, bias_wr_vld, bias_wr_addr, bias_wr_data,
           taps, st_data, st_bias, first, out_data, pre_data, out_vld, pre_vld,
           err_pend, err_drop
  );

  modport master (
    output active, active_normal, active_pre, active_start_d, fb_en, bias_fb_en,
           data_valid, data_write_addr, data_value, data_read_addr,
           tap_address, bias_wr_address, error_valid, error_value, error_sub_address,
           error_phase, error_phase_read, error_update_first, error_update_latch,
           error_tap_update_out, st_data_out, st_data_out_pre, st_bias_out, st_tap_out,
           data_rd_data, bias_rd_data, tap_rd_data, out_rdy, pre_rdy,
    input  data_wr_vld, data_wr_addr, data_wr_data, data_rd_vld, data_rd_addr,
           tap_rd_vld, tap_rd_addr, tap_wr_vld, tap_wr_addr, tap_wr_data,
           tap_sub_vld, tap_sub_addr, tap_sub_data, tap_inter, tap_inter_first,
           bias_rd_vld, bias_rd_addr, bias_wr_vld, bias_wr_addr, bias_wr_data,
           taps, st_data, st_bias, first, out_data, pre_data, out_vld, pre_vld,
           err_pend, err_drop
  );
endinterface

// File: rtl/full_stage_ctrl_param.sv
// Control block for one fully-connected stage: memory port steering, delayed
// tap/bias write-back, error-vs-feedback tap write arbitration, output holding regs.

// One valid/ready holding register; data is frozen while vld & ~rdy.
module fsc_hold_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             act,
  input  logic             rdy,
  input  logic [WIDTH-1:0] din,
  output logic             vld,
  output logic [WIDTH-1:0] dout
);
  always_ff @(posedge clk) begin
    if (reset) begin
      vld  <= 1'b0;
      dout <= '0;
    end else if (act && (!vld || rdy)) begin
      vld  <= 1'b1;
      dout <= din;
    end else if (rdy) begin
      vld  <= 1'b0;
    end
  end
endmodule

module full_stage_ctrl_param #(
  parameter int WIDTH       = 32,
  parameter int NTAPS       = 6,
  parameter int DATA_AW     = 6,
  parameter int TAP_AW      = 4,
  parameter int PHASE_W     = 2,
  parameter int ERR_BASE    = 12,
  parameter int TAP_FB_LAT  = 5,
  parameter int BIAS_FB_LAT = 4
) (
  input logic clk,
  input logic reset,
  full_stage_ctrl_param_if.slave bus
);
  localparam logic [TAP_AW-1:0] ERR_BASE_A = TAP_AW'(ERR_BASE);
  localparam int NHOLD = 2;

  typedef struct packed {
    logic [PHASE_W-1:0] phase;
    logic [31:0]        sub_addr;
    logic [WIDTH-1:0]   value;
  } err_req_t;

  // pass-through wiring
  assign bus.data_wr_vld     = bus.data_valid;
  assign bus.data_wr_addr    = bus.data_write_addr;
  assign bus.data_wr_data    = bus.data_value;
  assign bus.data_rd_addr    = bus.data_read_addr;
  assign bus.data_rd_vld     = bus.active_normal;
  assign bus.first           = bus.active_start_d;
  assign bus.st_data         = bus.data_rd_data;
  assign bus.st_bias         = bus.bias_rd_data;
  assign bus.taps            = bus.tap_rd_data;
  assign bus.tap_inter       = bus.error_tap_update_out;
  assign bus.tap_inter_first = bus.error_update_first;
  assign bus.tap_wr_data     = bus.st_tap_out;
  assign bus.bias_wr_data    = bus.st_bias_out;
  assign bus.tap_rd_vld      = bus.active_normal;
  assign bus.bias_rd_vld     = bus.active_normal;
  assign bus.bias_rd_addr    = bus.tap_address;
  assign bus.bias_wr_addr    = bus.bias_wr_address;

  logic [TAP_AW-1:0] rd_addr;
  assign rd_addr = bus.error_update_first ? ERR_BASE_A + TAP_AW'(bus.error_phase_read)
                                          : bus.tap_address;
  assign bus.tap_rd_addr = rd_addr;

  // write-back delay line: stage k holds the request issued k cycles ago
  logic                               wb_req;
  logic [TAP_FB_LAT:1]                vld_pipe;
  logic [TAP_FB_LAT:1][TAP_AW-1:0]    addr_pipe;
  logic                               fb_hit;
  logic [TAP_AW-1:0]                  fb_addr;

  assign wb_req  = bus.error_update_latch & ~bus.error_update_first;
  assign fb_hit  = vld_pipe[TAP_FB_LAT];
  assign fb_addr = addr_pipe[TAP_FB_LAT];
  assign bus.bias_wr_vld = bus.bias_fb_en & vld_pipe[BIAS_FB_LAT];

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe  <= '0;
      addr_pipe <= '0;
    end else begin
      vld_pipe[1]  <= wb_req;
      addr_pipe[1] <= rd_addr;
      for (int k = 2; k <= TAP_FB_LAT; k++) begin
        vld_pipe[k]  <= vld_pipe[k-1];
        addr_pipe[k] <= addr_pipe[k-1];
      end
    end
  end

  // tap write arbitration: feedback > pending error > fresh error
  err_req_t pend, err_in;
  logic     pend_vld, drop;
  logic     fb_win;

  assign err_in = '{phase: bus.error_phase, sub_addr: bus.error_sub_address, value: bus.error_value};
  assign fb_win = fb_hit & bus.fb_en;

  always_comb begin
    bus.tap_wr_vld   = 1'b0;
    bus.tap_wr_addr  = fb_addr;
    bus.tap_sub_vld  = 1'b0;
    bus.tap_sub_addr = err_in.sub_addr;
    bus.tap_sub_data = err_in.value;
    if (fb_win) begin
      bus.tap_wr_vld   = 1'b1;
    end else if (pend_vld) begin
      bus.tap_wr_vld   = 1'b1;
      bus.tap_sub_vld  = 1'b1;
      bus.tap_wr_addr  = ERR_BASE_A + TAP_AW'(pend.phase);
      bus.tap_sub_addr = pend.sub_addr;
      bus.tap_sub_data = pend.value;
    end else if (bus.error_valid) begin
      bus.tap_wr_vld   = 1'b1;
      bus.tap_sub_vld  = 1'b1;
      bus.tap_wr_addr  = ERR_BASE_A + TAP_AW'(err_in.phase);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_vld <= 1'b0;
      pend     <= '0;
      drop     <= 1'b0;
    end else if (fb_win) begin
      if (bus.error_valid) begin
        if (!pend_vld) begin
          pend_vld <= 1'b1;
          pend     <= err_in;
        end else begin
          drop     <= 1'b1;
        end
      end
    end else if (pend_vld) begin
      // buffer drains this cycle; a new error can refill it behind the drain
      pend_vld <= bus.error_valid;
      if (bus.error_valid) pend <= err_in;
    end
  end

  assign bus.err_pend = pend_vld;
  assign bus.err_drop = drop;

  // holding registers: lane 0 = out, lane 1 = pre
  logic [NHOLD-1:0]            h_act, h_rdy, h_vld;
  logic [NHOLD-1:0][WIDTH-1:0] h_din, h_dout;

  assign h_act = {bus.active_pre, bus.active};
  assign h_rdy = {bus.pre_rdy, bus.out_rdy};
  assign h_din = {bus.st_data_out_pre, bus.st_data_out};

  for (genvar g = 0; g < NHOLD; g++) begin : g_hold
    fsc_hold_reg #(.WIDTH(WIDTH)) u_hold (
      .clk  (clk),
      .reset(reset),
      .act  (h_act[g]),
      .rdy  (h_rdy[g]),
      .din  (h_din[g]),
      .vld  (h_vld[g]),
      .dout (h_dout[g])
    );
  end

  assign bus.out_vld  = h_vld[0];
  assign bus.out_data = h_dout[0];
  assign bus.pre_vld  = h_vld[1];
  assign bus.pre_data = h_dout[1];
endmodule

// File: doc/full_stage_ctrl_param.md
Name: full_stage_ctrl_param

Overview:
- Parametrised control block for one fully-connected stage.
- Drives the stage's data, tap and bias memories, and runs the delayed tap/bias write-back pipelines with lengths set by parameters.
- Arbitrates error-update writes against tap feedback writes through a one-entry pending buffer.
- Presents stage outputs through valid/ready holding registers; sits between the stage controller and the stage datapath.

Parameters:
- WIDTH, 32, scalar word width (float_24_8 packed).
- NTAPS, 6, taps per tap-memory word.
- DATA_AW, 6, data memory address width.
- TAP_AW, 4, tap/bias memory address width.
- PHASE_W, 2, error phase width.
- ERR_BASE, 12, tap address of the first error-accumulation row.
- TAP_FB_LAT, 5, cycles from tap read to tap feedback write (>=1).
- BIAS_FB_LAT, 4, cycles from tap read to bias feedback write (>=1, <=TAP_FB_LAT).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- active, active_normal, active_pre, active_start_d  in  1 each  stage phase flags
- fb_en, bias_fb_en  in  1 each  enable tap / bias feedback writes
- data_valid  in  1;  data_write_addr  in  DATA_AW;  data_value  in  WIDTH  data memory write request
- data_read_addr  in  DATA_AW  data read address
- tap_address  in  TAP_AW;  bias_wr_address  in  TAP_AW
- error_valid  in  1;  error_value  in  WIDTH;  error_sub_address  in  32;  error_phase, error_phase_read  in  PHASE_W
- error_update_first, error_update_latch, error_tap_update_out  in  1 each
- st_data_out, st_data_out_pre, st_bias_out  in  WIDTH  datapath results
- st_tap_out  in  WIDTH*NTAPS  updated tap word
- data_rd_data, bias_rd_data  in  WIDTH;  tap_rd_data  in  WIDTH*NTAPS  memory read data
- out_rdy, pre_rdy  in  1  downstream ready
- data_wr_vld, data_wr_addr, data_wr_data, data_rd_vld, data_rd_addr  out  data memory port
- tap_rd_vld, tap_rd_addr, tap_wr_vld, tap_wr_addr, tap_wr_data, tap_sub_vld, tap_sub_addr, tap_sub_data, tap_inter, tap_inter_first  out  tap memory port
- bias_rd_vld, bias_rd_addr, bias_wr_vld, bias_wr_addr, bias_wr_data  out  bias memory port
- taps  out  WIDTH*NTAPS;  st_data, st_bias  out  WIDTH;  first  out  1
- out_data, pre_data  out  WIDTH;  out_vld, pre_vld  out  1
- err_pend  out  1  pending buffer occupied
- err_drop  out  1  sticky error-drop flag

Behaviour:
- Pass-through, combinational:
  - data_wr_* = data_valid/data_write_addr/data_value.
  - data_rd_addr = data_read_addr; data_rd_vld = active_normal.
  - first = active_start_d; st_data = data_rd_data; st_bias = bias_rd_data; taps = tap_rd_data.
  - tap_inter = error_tap_update_out; tap_inter_first = error_update_first; tap_wr_data = st_tap_out; bias_wr_data = st_bias_out.
- Tap read address:
  - tap_rd_addr = error_update_first ? ERR_BASE + zero-extended error_phase_read : tap_address, computed modulo 2^TAP_AW.
  - tap_rd_vld = bias_rd_vld = active_normal; bias_rd_addr = tap_address.
- Write-back pipeline:
  - wb_req = error_update_latch & ~error_update_first.
  - A TAP_FB_LAT-deep shift register carries {wb_req, tap_rd_addr}; fb_hit = its valid output.
  - bias_wr_vld = bias_fb_en & (wb_req delayed BIAS_FB_LAT); bias_wr_addr = bias_wr_address.
  - All pipeline stages reset to 0.
- Tap write arbitration, evaluated each cycle in priority order:
  1. fb_hit & fb_en:
     - tap_wr_vld=1, tap_wr_addr = delayed address, tap_sub_vld=0.
     - A coincident error write (error_valid) goes into the pending buffer if it is empty.
     - If the buffer is full, the error write is lost and err_drop is set (sticky until reset).
  2. Else if pending buffer full: write the buffered entry (tap_wr_vld=1, tap_sub_vld=1, buffered phase/sub_addr/value), then clear the buffer. A simultaneous new error_valid is captured into the buffer in the same cycle.
  3. Else if error_valid: write directly (tap_wr_vld=1, tap_sub_vld=1, addr = ERR_BASE + error_phase, sub_addr/sub_data from inputs).
  4. Else: tap_wr_vld=0, tap_sub_vld=0.
- fb_hit with fb_en=0 issues no write and does not block errors.
- err_pend = buffer occupied.
- Output holding registers (out and pre, identical logic):
  - Load st_data_out (or st_data_out_pre) and set vld when active (or active_pre) and (vld==0 or rdy==1).
  - Clear vld when rdy is high and there is no new load.
  - Data holds stable while vld & ~rdy; new results arriving in that window are not accepted.
  - Latency: 1 cycle.
- Reset:
  - All outputs from registers are 0: out_vld, pre_vld, out_data, pre_data, err_pend, err_drop, pipelines.
  - Reset mid-write-back discards every in-flight feedback write and any pending error.

Test Plan:
- TAP_FB_LAT=5: latch=1, first=0, tap_address=3 at cycle 0 -> tap_wr_vld=1, tap_wr_addr=3, tap_sub_vld=0 at cycle 5; bias_wr_vld=1 at cycle 4.
- error_update_first=1, error_phase_read=2 -> tap_rd_addr=14. error_valid=1, error_phase=1, value 0x3F800000 -> tap_wr_addr=13, tap_sub_vld=1, tap_sub_data=0x3F800000 the same cycle.
- Collision: fb_hit and error_valid in cycle N -> feedback written at N; error written at N+1 with buffered phase/value; err_pend=1 for exactly one cycle.
- Collision in cycles N and N+1 with no free slot (fb_hit at N, N+1; error_valid at N, N+1) -> second error dropped; err_drop=1 and held until reset.
- out_rdy=0 with active pulsed at values A then B -> out_data stays A with out_vld=1; raising out_rdy -> vld clears next cycle (B not accepted).
- Assert reset 2 cycles after a write-back request -> no tap_wr_vld at the original cycle 5; err_pend=err_drop=out_vld=0.
